// File: rtl/dac_update_scheduler.sv
// Arbitrates host (s0) and stream (s1) samples onto the SPI DAC controller, holds the
// sample until LDAC latches it, spaces updates by MIN_GAP and flags hung transfers.
module dac_update_scheduler #(
  parameter int MIN_GAP = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        enable,
  input  logic        s0_valid,
  input  logic [15:0] s0_data,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic [15:0] s1_data,
  output logic        s1_ready,
  output logic [15:0] dac_data,
  output logic        dac_en,
  output logic        renew,
  input  logic        spi_csn,
  input  logic        spi_ldac,
  output logic        busy,
  output logic        last_src,
  output logic        err_timeout,
  input  logic        clr_err
);

  localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);
  // Checked one cycle early so the flag is visible TIMEOUT cycles after renew.
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CS,
    WAIT_LDAC_LO,
    WAIT_LDAC_HI
  } state_t;

  state_t           state;
  logic [GAP_W-1:0] gap;
  logic [TO_W-1:0]  tcnt;
  logic             grant0;
  logic             grant1;

  assign s0_ready = (state == IDLE) && (gap == '0) && enable;
  assign s1_ready = s0_ready && !s0_valid;
  assign grant0   = s0_ready && s0_valid;
  assign grant1   = s1_ready && s1_valid;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= IDLE;
      gap         <= '0;
      tcnt        <= '0;
      dac_data    <= '0;
      dac_en      <= 1'b0;
      renew       <= 1'b0;
      busy        <= 1'b0;
      last_src    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      dac_en <= enable;
      renew  <= 1'b0;
      // A timeout set below in the same cycle overrides this clear.
      if (clr_err) err_timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (gap != '0) gap <= gap - GAP_W'(1);
          if (grant0 || grant1) begin
            dac_data <= grant0 ? s0_data : s1_data;
            last_src <= grant1;
            renew    <= 1'b1;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT_CS;
        end
        default: begin
          tcnt <= tcnt + TO_W'(1);
          if (state == WAIT_LDAC_HI && spi_ldac) begin
            state <= IDLE;
            busy  <= 1'b0;
            gap   <= GAP_LOAD;
          end else if (tcnt == TO_LAST) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
            gap         <= GAP_LOAD;
          end else if (state == WAIT_CS && !spi_csn) begin
            state <= WAIT_LDAC_LO;
          end else if (state == WAIT_LDAC_LO && !spi_ldac) begin
            state <= WAIT_LDAC_HI;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Bench for dac_update_scheduler: directed scenarios plus random traffic, checked every
// cycle against a timestamp-based transfer model and an SPI controller model.
module tb_dac_update_scheduler;

  localparam int MIN_GAP = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_l, enable, s0_valid, s1_valid, s0_ready, s1_ready;
  logic        dac_en, renew, spi_csn, spi_ldac, busy, last_src, err_timeout, clr_err;
  logic [15:0] s0_data, s1_data, dac_data;

  always #5 clk = ~clk;

  dac_update_scheduler #(.MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_l(rst_l), .enable(enable),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .dac_data(dac_data), .dac_en(dac_en), .renew(renew),
    .spi_csn(spi_csn), .spi_ldac(spi_ldac), .busy(busy),
    .last_src(last_src), .err_timeout(err_timeout), .clr_err(clr_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // SPI controller model: CSn low two cycles after the renew cycle, then an LDAC pulse.
  bit hung = 1'b0;
  initial begin
    spi_csn = 1'b1;
    spi_ldac = 1'b1;
    forever begin
      @(negedge clk);
      if (renew === 1'b1 && rst_l === 1'b1 && !hung) begin
        repeat (2) @(posedge clk);
        #1 spi_csn = 1'b0;
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1 spi_ldac = 1'b0;
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1 spi_ldac = 1'b1;
        spi_csn = 1'b1;
      end
    end
  end

  // Transfer model: one grant opens a transfer, the LDAC low->high (or the timeout) closes it.
  bit          busy_m, saw_low, exp_renew, exp_src, exp_err, exp_en, acc0, acc1;
  bit          rdy, grant, fin, set_err;
  logic [15:0] exp_data;
  int          g_cyc, next_ok, end_cyc, renew_cnt;

  always @(negedge clk) begin
    if (rst_l !== 1'b1) begin
      check("rst_renew", renew, 0);
      check("rst_busy", busy, 0);
      check("rst_data", dac_data, 0);
      check("rst_src", last_src, 0);
      check("rst_err", err_timeout, 0);
      check("rst_dac_en", dac_en, 0);
      check("rst_s0_ready", s0_ready, enable);
      busy_m = 0; saw_low = 0; exp_renew = 0; exp_src = 0; exp_err = 0; exp_en = 0;
      acc0 = 0; acc1 = 0; exp_data = '0; next_ok = 0;
    end else begin
      if (renew === 1'b1) renew_cnt++;
      rdy = enable && !busy_m && (cyc >= next_ok);
      check("s0_ready", s0_ready, rdy);
      check("s1_ready", s1_ready, rdy && !s0_valid);
      check("renew", renew, exp_renew);
      check("busy", busy, busy_m);
      check("dac_data", dac_data, exp_data);
      check("last_src", last_src, exp_src);
      check("err_timeout", err_timeout, exp_err);
      check("dac_en", dac_en, exp_en);

      grant = rdy && (s0_valid || s1_valid);
      acc0 = grant && s0_valid;
      acc1 = grant && !s0_valid;
      fin = 0;
      set_err = 0;
      if (busy_m && cyc > g_cyc + 1) begin
        if (saw_low && spi_ldac) fin = 1;
        else if (cyc == g_cyc + TIMEOUT) begin fin = 1; set_err = 1; end
        if (!spi_ldac) saw_low = 1;
      end
      if (fin) begin
        busy_m = 0;
        end_cyc = cyc;
        next_ok = cyc + 1 + MIN_GAP;
      end
      exp_err = set_err || (exp_err && !clr_err);
      exp_renew = grant;
      exp_en = enable;
      if (grant) begin
        busy_m = 1;
        saw_low = 0;
        g_cyc = cyc;
        exp_data = s0_valid ? s0_data : s1_data;
        exp_src = !s0_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input bit src);
    int n = 0;
    do begin tick(); n++; end while (!(src ? acc1 : acc0) && n < 200);
    if (!(src ? acc1 : acc0)) check("wait_acc_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (busy_m && n < 100) begin tick(); n++; end
    if (busy_m) check("wait_done_timeout", 0, 1);
  endtask

  task automatic send0(input logic [15:0] d);
    s0_data = d;
    s0_valid = 1'b1;
    wait_acc(0);
    s0_valid = 1'b0;
  endtask

  logic [15:0] vals[4];
  int          rc0, r_cyc, n;

  initial begin
    rst_l = 1'b0; enable = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
    s0_data = '0; s1_data = '0; clr_err = 1'b0;
    repeat (3) tick();
    rst_l = 1'b1;
    tick();

    // Single host write
    enable = 1'b1;
    rc0 = renew_cnt;
    send0(16'hA5C3);
    wait_done();
    check("A_busy_low", busy, 0);
    check("A_data", dac_data, 16'hA5C3);
    check("A_src", last_src, 0);
    check("A_renews", renew_cnt - rc0, 1);

    // Both valid: s0 wins, s1 follows after the gap
    repeat (MIN_GAP + 3) tick();
    s0_data = 16'h1111; s1_data = 16'h2222;
    s0_valid = 1'b1; s1_valid = 1'b1;
    wait_acc(0);
    s0_valid = 1'b0;
    check("B_first_src", last_src, 0);
    check("B_first_data", dac_data, 16'h1111);
    wait_acc(1);
    s1_valid = 1'b0;
    check("B_second_src", last_src, 1);
    check("B_second_data", dac_data, 16'h2222);
    check("B_gap", g_cyc - end_cyc, MIN_GAP + 1);
    wait_done();

    // Stream burst of four samples, valid held high
    repeat (MIN_GAP + 3) tick();
    foreach (vals[i]) vals[i] = 16'($urandom);
    rc0 = renew_cnt;
    s1_data = vals[0];
    s1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_acc(1);
      check("C_data", dac_data, vals[i]);
      if (i < 3) s1_data = vals[i + 1];
      else s1_valid = 1'b0;
    end
    wait_done();
    check("C_renews", renew_cnt - rc0, 4);

    // Hung controller: timeout, then set and clear in the same cycle
    repeat (MIN_GAP + 3) tick();
    hung = 1'b1;
    send0(16'hDEAD);
    r_cyc = cyc;
    n = 0;
    while (err_timeout !== 1'b1 && n < 40) begin tick(); n++; end
    check("D_err_cycle", cyc - r_cyc, TIMEOUT);
    check("D_idle", busy, 0);
    repeat (MIN_GAP + 3) tick();
    send0(16'hBEEF);
    r_cyc = cyc;
    repeat (TIMEOUT - 1) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("D_set_wins", err_timeout, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("D_clear", err_timeout, 0);
    hung = 1'b0;

    // enable drops while LDAC is low
    repeat (MIN_GAP + 3) tick();
    send0(16'h0BEE);
    n = 0;
    while (spi_ldac === 1'b1 && n < 50) begin @(posedge clk); #2; n++; end
    enable = 1'b0;
    s0_data = 16'h7777;
    s0_valid = 1'b1;
    tick();
    check("E_dac_en", dac_en, 0);
    wait_done();
    check("E_completed", busy, 0);
    repeat (MIN_GAP + 5) tick();
    check("E_no_grant", busy, 0);
    check("E_data_held", dac_data, 16'h0BEE);
    enable = 1'b1;
    wait_acc(0);
    s0_valid = 1'b0;
    check("E_late_data", dac_data, 16'h7777);
    wait_done();

    // Asynchronous reset while waiting for CSn
    repeat (MIN_GAP + 3) tick();
    hung = 1'b1;
    send0(16'h5A5A);
    tick();
    #2 rst_l = 1'b0;
    #1;
    check("F_renew", renew, 0);
    check("F_busy", busy, 0);
    check("F_data", dac_data, 0);
    check("F_src", last_src, 0);
    check("F_dac_en", dac_en, 0);
    @(posedge clk);
    #1 rst_l = 1'b1;
    hung = 1'b0;
    s0_data = 16'h1234;
    s0_valid = 1'b1;
    tick();
    check("F_first_grant", acc0, 1);
    s0_valid = 1'b0;
    check("F_grant_data", dac_data, 16'h1234);
    wait_done();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (acc0) s0_valid = 1'b0;
      if (acc1) s1_valid = 1'b0;
      if (!s0_valid && $urandom_range(11) == 0) begin s0_valid = 1'b1; s0_data = 16'($urandom); end
      if (!s1_valid && $urandom_range(3) == 0) begin s1_valid = 1'b1; s1_data = 16'($urandom); end
      enable = ($urandom_range(99) < 95);
      clr_err = ($urandom_range(39) == 0);
      hung = ($urandom_range(9) == 0);
      tick();
    end
    s0_valid = 1'b0; s1_valid = 1'b0; clr_err = 1'b0; hung = 1'b0; enable = 1'b1;
    wait_done();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 100000", cyc);
    $fatal(1);
  end

endmodule
